// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word and the
// request arbiter state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  // Index width for an n-entry selector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/req_arbiter_if.sv
// Signal bundle between the channel
// side, the arbiter and the memory port.
interface req_arbiter_if #(
  parameter int NCH = 2
);
  import cpu_types_pkg::*;

  localparam int IW = idx_w(NCH);

  logic                 CLK;
  logic                 nRST;
  logic [NCH-1:0]       ch_ren;
  logic [NCH-1:0]       ch_wen;
  word_t [NCH-1:0]      ch_addr;
  word_t [NCH-1:0]      ch_store;
  logic [NCH-1:0]       ch_hit;
  word_t                ch_load;
  logic                 mem_ren;
  logic                 mem_wen;
  word_t                mem_addr;
  word_t                mem_store;
  word_t                mem_load;
  logic                 mem_wait;
  logic [IW-1:0]        grant_id;
  logic                 timeout_err;

  modport arb (
    input  CLK, nRST,
    input  ch_ren, ch_wen,
    input  ch_addr, ch_store,
    output ch_hit, ch_load,
    output mem_ren, mem_wen,
    output mem_addr, mem_store,
    input  mem_load, mem_wait,
    output grant_id, timeout_err
  );

  modport tb (
    output CLK, nRST,
    output ch_ren, ch_wen,
    output ch_addr, ch_store,
    input  ch_hit, ch_load,
    input  mem_ren, mem_wen,
    input  mem_addr, mem_store,
    output mem_load, mem_wait,
    input  grant_id, timeout_err
  );

endinterface

// File: rtl/rr_picker.sv
// Round-robin selector: first requesting
// channel at or after the pointer wins.
module rr_picker
  import cpu_types_pkg::*;
#(
  parameter  int NCH = 2,
  localparam int IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_ptr,
  output logic [IW-1:0]  o_gnt,
  output logic           o_any
);

  // Scan farthest offset first so the
  // nearest requester is written last.
  always_comb begin
    int c;
    c     = 0;
    o_gnt = '0;
    o_any = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      c = (int'(i_ptr) + i) % NCH;
      if (i_req[c]) begin
        o_gnt = IW'(c);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// Multi-channel memory arbiter with one
// outstanding access and a stall watchdog.
module req_arbiter
  import cpu_types_pkg::*;
#(
  parameter  int NCH     = 2,
  parameter  int TIMEOUT = 255,
  localparam int IW      = idx_w(NCH)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NCH-1:0]  ch_ren,
  input  logic [NCH-1:0]  ch_wen,
  input  word_t [NCH-1:0] ch_addr,
  input  word_t [NCH-1:0] ch_store,
  output logic [NCH-1:0]  ch_hit,
  output word_t           ch_load,
  output logic            mem_ren,
  output logic            mem_wen,
  output word_t           mem_addr,
  output word_t           mem_store,
  input  word_t           mem_load,
  input  logic            mem_wait,
  output logic [IW-1:0]   grant_id,
  output logic            timeout_err
);

  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT - 1);
  localparam logic [NCH-1:0] ONE =
    {{(NCH-1){1'b0}}, 1'b1};

  arb_state_t      r_state;
  logic [IW-1:0]   r_ptr;
  logic [15:0]     r_wcnt;
  logic [NCH-1:0]  w_req;
  logic [IW-1:0]   w_pick;
  logic            w_any;

  assign w_req = ch_ren | ch_wen;

  rr_picker #(
    .NCH (NCH)
  ) u_pick (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick),
    .o_any (w_any)
  );

  // Grant, drive memory port, complete.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_wcnt      <= '0;
      grant_id    <= '0;
      ch_hit      <= '0;
      ch_load     <= '0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_store   <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          ch_hit <= '0;
          if (w_any) begin
            grant_id  <= w_pick;
            mem_addr  <= ch_addr[w_pick];
            mem_store <= ch_store[w_pick];
            mem_wen   <= ch_wen[w_pick];
            mem_ren   <= ~ch_wen[w_pick];
            r_wcnt    <= '0;
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!mem_wait) begin
            ch_load <= mem_load;
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            ch_hit  <= ONE << grant_id;
            r_ptr   <= (grant_id == IW'(NCH - 1))
                     ? '0 : grant_id + 1'b1;
            r_state <= DONE;
          end else begin
            if (r_wcnt != 16'hFFFF)
              r_wcnt <= r_wcnt + 16'd1;
            if (r_wcnt >= TO_LAST)
              timeout_err <= 1'b1;
          end
        end
        DONE: begin
          ch_hit  <= '0;
          r_state <= IDLE;
        end
        default: begin
          ch_hit  <= '0;
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed table, corner sequences and a
// random run against a transaction model.
module tb_req_arbiter;
  import cpu_types_pkg::*;

  localparam int NCH = 2;
  localparam int TO  = 4;

  req_arbiter_if #(.NCH(NCH)) bus();

  req_arbiter #(
    .NCH     (NCH),
    .TIMEOUT (TO)
  ) dut (
    .CLK         (bus.CLK),
    .nRST        (bus.nRST),
    .ch_ren      (bus.ch_ren),
    .ch_wen      (bus.ch_wen),
    .ch_addr     (bus.ch_addr),
    .ch_store    (bus.ch_store),
    .ch_hit      (bus.ch_hit),
    .ch_load     (bus.ch_load),
    .mem_ren     (bus.mem_ren),
    .mem_wen     (bus.mem_wen),
    .mem_addr    (bus.mem_addr),
    .mem_store   (bus.mem_store),
    .mem_load    (bus.mem_load),
    .mem_wait    (bus.mem_wait),
    .grant_id    (bus.grant_id),
    .timeout_err (bus.timeout_err)
  );

  initial begin
    bus.CLK = 1'b0;
    forever #5 bus.CLK = ~bus.CLK;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus.CLK);
    #1;
  endtask

  task automatic idle_in();
    bus.ch_ren    = '0;
    bus.ch_wen    = '0;
    bus.ch_addr   = '0;
    bus.ch_store  = '0;
    bus.mem_load  = '0;
    bus.mem_wait  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge bus.CLK);
    bus.nRST = 1'b0;
    @(negedge bus.CLK);
    @(negedge bus.CLK);
    bus.nRST = 1'b1;
    #1;
  endtask

  // Transaction model: phase 0 waiting,
  // 1 memory busy, 2 completion cycle.
  int    e_ph, e_gid, e_last, e_wcnt;
  logic  [NCH-1:0] e_hit;
  logic  e_ren, e_wen, e_err;
  word_t e_addr, e_store, e_load;

  task automatic m_reset();
    e_ph = 0; e_gid = 0; e_last = NCH - 1;
    e_wcnt = 0; e_hit = '0;
    e_ren = 0; e_wen = 0; e_err = 0;
    e_addr = '0; e_store = '0; e_load = '0;
  endtask

  task automatic m_step();
    int best, bd, d;
    if (e_ph == 0) begin
      best = -1; bd = NCH;
      for (int c = 0; c < NCH; c++) begin
        d = (c - e_last - 1 + 2 * NCH) % NCH;
        if ((bus.ch_ren[c] || bus.ch_wen[c])
            && d < bd) begin
          bd = d; best = c;
        end
      end
      if (best >= 0) begin
        e_gid   = best;
        e_addr  = bus.ch_addr[best];
        e_store = bus.ch_store[best];
        e_wen   = bus.ch_wen[best];
        e_ren   = !bus.ch_wen[best];
        e_wcnt  = 0;
        e_ph    = 1;
      end
    end else if (e_ph == 1) begin
      if (!bus.mem_wait) begin
        e_load = bus.mem_load;
        e_ren  = 0; e_wen = 0;
        e_hit  = '0;
        e_hit[e_gid] = 1'b1;
        e_last = e_gid;
        e_ph   = 2;
      end else begin
        e_wcnt++;
        if (e_wcnt >= TO) e_err = 1;
      end
    end else begin
      e_hit = '0;
      e_ph  = 0;
    end
  endtask

  task automatic m_cmp();
    chk("rnd_gid", 32'(bus.grant_id),
        32'(e_gid));
    chk("rnd_hit", 32'(bus.ch_hit), 32'(e_hit));
    chk("rnd_mren", 32'(bus.mem_ren),
        32'(e_ren));
    chk("rnd_mwen", 32'(bus.mem_wen),
        32'(e_wen));
    chk("rnd_maddr", bus.mem_addr, e_addr);
    chk("rnd_mstore", bus.mem_store, e_store);
    chk("rnd_load", bus.ch_load, e_load);
    chk("rnd_err", 32'(bus.timeout_err),
        32'(e_err));
  endtask

  typedef struct {
    logic [1:0] ren;
    logic [1:0] wen;
    logic       mw;
    word_t      ml;
    logic [1:0] hit;
    logic       mren;
    logic       mwen;
    word_t      maddr;
    word_t      mstore;
    word_t      load;
    logic       gid;
  } vec_t;

  vec_t tbl[6];
  logic [NCH-1:0] hq[$];
  logic [NCH-1:0] prev;

  initial begin
    tbl[0] = '{2'b01, 2'b00, 1'b0, 32'hDEADBEEF,
               2'b00, 1'b1, 1'b0, 32'h100,
               32'h0, 32'h0, 1'b0};
    tbl[1] = '{2'b00, 2'b00, 1'b0, 32'hDEADBEEF,
               2'b01, 1'b0, 1'b0, 32'h100,
               32'h0, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{2'b00, 2'b00, 1'b0, 32'h0,
               2'b00, 1'b0, 1'b0, 32'h100,
               32'h0, 32'hDEADBEEF, 1'b0};
    tbl[3] = '{2'b10, 2'b10, 1'b1, 32'h0,
               2'b00, 1'b0, 1'b1, 32'h200,
               32'h12345678, 32'hDEADBEEF, 1'b1};
    tbl[4] = '{2'b10, 2'b10, 1'b0, 32'hCAFE0000,
               2'b10, 1'b0, 1'b0, 32'h200,
               32'h12345678, 32'hCAFE0000, 1'b1};
    tbl[5] = '{2'b00, 2'b00, 1'b0, 32'h0,
               2'b00, 1'b0, 1'b0, 32'h200,
               32'h12345678, 32'hCAFE0000, 1'b1};

    idle_in();
    bus.nRST = 1'b0;
    #12;
    chk("rst_hit", 32'(bus.ch_hit), 32'h0);
    chk("rst_mren", 32'(bus.mem_ren), 32'h0);
    chk("rst_mwen", 32'(bus.mem_wen), 32'h0);
    chk("rst_maddr", bus.mem_addr, 32'h0);
    chk("rst_load", bus.ch_load, 32'h0);
    chk("rst_gid", 32'(bus.grant_id), 32'h0);
    chk("rst_err", 32'(bus.timeout_err), 32'h0);
    do_reset();

    // Single read then write-priority access.
    bus.ch_addr[0]  = 32'h100;
    bus.ch_addr[1]  = 32'h200;
    bus.ch_store[1] = 32'h12345678;
    for (int i = 0; i < 6; i++) begin
      bus.ch_ren   = tbl[i].ren;
      bus.ch_wen   = tbl[i].wen;
      bus.mem_wait = tbl[i].mw;
      bus.mem_load = tbl[i].ml;
      tick();
      chk("tbl_hit", 32'(bus.ch_hit),
          32'(tbl[i].hit));
      chk("tbl_mren", 32'(bus.mem_ren),
          32'(tbl[i].mren));
      chk("tbl_mwen", 32'(bus.mem_wen),
          32'(tbl[i].mwen));
      chk("tbl_maddr", bus.mem_addr,
          tbl[i].maddr);
      chk("tbl_mstore", bus.mem_store,
          tbl[i].mstore);
      chk("tbl_load", bus.ch_load, tbl[i].load);
      chk("tbl_gid", 32'(bus.grant_id),
          32'(tbl[i].gid));
      chk("tbl_err", 32'(bus.timeout_err), 32'h0);
    end

    // Contention: both channels held.
    idle_in();
    bus.ch_ren = 2'b11;
    prev = '0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (bus.ch_hit != '0) begin
        hq.push_back(bus.ch_hit);
        chk("rr_gap", 32'(prev), 32'h0);
      end
      prev = bus.ch_hit;
    end
    chk("rr_count", 32'(hq.size()), 32'd4);
    for (int k = 0; k < hq.size(); k++)
      chk("rr_order", 32'(hq[k]),
          (k % 2 == 0) ? 32'h1 : 32'h2);
    bus.ch_ren = '0;
    tick();

    // Stall with a changing channel address.
    bus.ch_ren     = 2'b01;
    bus.ch_addr[0] = 32'h300;
    bus.mem_wait   = 1'b1;
    tick();
    chk("stl_addr0", bus.mem_addr, 32'h300);
    bus.ch_addr[0] = 32'h999;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stl_addr", bus.mem_addr, 32'h300);
      chk("stl_hit", 32'(bus.ch_hit), 32'h0);
      chk("stl_mren", 32'(bus.mem_ren), 32'h1);
    end
    bus.mem_wait = 1'b0;
    tick();
    chk("stl_done", 32'(bus.ch_hit), 32'h1);
    chk("stl_err", 32'(bus.timeout_err), 32'h1);
    bus.ch_ren = '0;
    tick();
    chk("stl_pulse", 32'(bus.ch_hit), 32'h0);
    do_reset();
    chk("rst2_err", 32'(bus.timeout_err), 32'h0);

    // Watchdog: ten wait cycles.
    bus.ch_ren     = 2'b10;
    bus.ch_addr[1] = 32'h400;
    bus.mem_wait   = 1'b1;
    tick();
    chk("to_gid", 32'(bus.grant_id), 32'h1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("to_err", 32'(bus.timeout_err),
          (k >= TO) ? 32'h1 : 32'h0);
    end
    bus.mem_wait = 1'b0;
    tick();
    chk("to_hit", 32'(bus.ch_hit), 32'h2);
    bus.ch_ren = '0;
    tick();
    tick();
    chk("to_sticky", 32'(bus.timeout_err), 32'h1);

    // Reset between edges mid-access.
    bus.ch_ren   = 2'b01;
    bus.mem_wait = 1'b1;
    tick();
    chk("ar_mren1", 32'(bus.mem_ren), 32'h1);
    #2;
    bus.nRST = 1'b0;
    #1;
    chk("ar_mren0", 32'(bus.mem_ren), 32'h0);
    chk("ar_mwen0", 32'(bus.mem_wen), 32'h0);
    chk("ar_err0", 32'(bus.timeout_err), 32'h0);
    bus.ch_ren   = '0;
    bus.mem_wait = 1'b0;
    #1;
    bus.nRST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ar_nohit", 32'(bus.ch_hit), 32'h0);
      chk("ar_idle", 32'(bus.mem_ren), 32'h0);
    end
    bus.ch_ren     = 2'b01;
    bus.ch_addr[0] = 32'h500;
    tick();
    chk("ar_new", bus.mem_addr, 32'h500);
    bus.ch_ren = '0;
    tick();
    chk("ar_newhit", 32'(bus.ch_hit), 32'h1);
    tick();

    // Random run against the model.
    idle_in();
    do_reset();
    m_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < NCH; c++) begin
        bus.ch_ren[c]   = ($urandom_range(0, 2) == 0);
        bus.ch_wen[c]   = ($urandom_range(0, 3) == 0);
        bus.ch_addr[c]  = $urandom;
        bus.ch_store[c] = $urandom;
      end
      bus.mem_load = $urandom;
      bus.mem_wait = ($urandom_range(0, 2) == 0);
      m_step();
      tick();
      m_cmp();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter NCH, default 2, number of requesting channels (2..8).
REQ-002 Parameter TIMEOUT, default 255, mem_wait cycles before timeout_err sets (1..65535).
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 ch_ren  input  NCH  per-channel read request.
REQ-006 ch_wen  input  NCH  per-channel write request.
REQ-007 ch_addr  input  NCH x word_t  per-channel address.
REQ-008 ch_store  input  NCH x word_t  per-channel write data.
REQ-009 ch_hit  output  NCH  one-cycle completion pulse to the granted channel.
REQ-010 ch_load  output  word_t  read data; valid while the matching ch_hit bit is high.
REQ-011 mem_ren, mem_wen  output  1 each  memory-port read/write strobes.
REQ-012 mem_addr, mem_store  output  word_t each  memory-port address and write data.
REQ-013 mem_load  input  word_t  memory read data; sampled when mem_wait is low.
REQ-014 mem_wait  input  1  memory busy; low means access completes this cycle.
REQ-015 grant_id  output  clog2(NCH)  channel currently owning the memory port.
REQ-016 timeout_err  output  1  sticky flag, set on memory timeout.

Function
REQ-017 FSM states IDLE, ACCESS, DONE; all outputs registered or driven from registered state only.
REQ-018 IDLE: if any ch_ren|ch_wen bit is set, select a channel round-robin starting at rr_ptr, latch its address, store data and op into internal registers, load grant_id, go to ACCESS; otherwise stay.
REQ-019 Op latch: ch_wen has priority over ch_ren when both are set on one channel; that access is a write.
REQ-020 ACCESS: mem_ren/mem_wen/mem_addr/mem_store driven from latched values, held stable until completion, independent of channel inputs.
REQ-021 ACCESS with mem_wait low: capture mem_load into ch_load, go to DONE; rr_ptr := grant_id+1, wrapping from NCH-1 to 0.
REQ-022 DONE: ch_hit[grant_id]=1 for exactly this cycle, all other ch_hit bits 0, mem_ren=mem_wen=0; next state IDLE unconditionally.
REQ-023 Minimum latency: request sampled in IDLE at cycle 0, memory strobe at cycle 1, ch_hit at cycle 2 when mem_wait is low at cycle 1.
REQ-024 Requester holds request until ch_hit; a request dropped mid-ACCESS still completes on the memory port and still pulses ch_hit.
REQ-025 A channel re-asserting its request in the cycle after ch_hit is eligible only after all other pending channels (round-robin fairness); with a single requester it is re-granted immediately.
REQ-026 ch_load holds its last captured value outside DONE; it updates only on ACCESS completion, including writes (value then undefined-but-stable mem_load).
REQ-027 Wait counter: cleared on IDLE->ACCESS, incremented each ACCESS cycle with mem_wait high, saturating; reaching TIMEOUT sets timeout_err; the transaction continues waiting (no abort).
REQ-028 timeout_err cleared only by reset.

Reset
REQ-029 nRST low asynchronously forces: state IDLE, rr_ptr 0, grant_id 0, ch_hit 0, ch_load 0, mem_ren 0, mem_wen 0, mem_addr 0, mem_store 0, wait counter 0, timeout_err 0.
REQ-030 Reset during ACCESS abandons the transaction; no ch_hit is issued for it after reset release.

Structure
REQ-031 word_t from cpu_types_pkg; arb_state_t enum (IDLE, ACCESS, DONE) added to cpu_types_pkg.
REQ-032 One sub-module rr_picker: combinational round-robin selector (request vector, rr_ptr -> grant index, any_req).
REQ-033 Port signals grouped in interface req_arbiter_if with modports arb and tb.

Verification
REQ-034 Single read: ch_ren=01, ch_addr[0]=0x100, mem_wait low, mem_load=0xDEADBEEF -> mem_ren high cycle 1 at addr 0x100, ch_hit=01 with ch_load=0xDEADBEEF at cycle 2.
REQ-035 Contention: ch_ren=11 held, rr_ptr 0 -> grants 0,1,0,1; each ch_hit pulse exactly one cycle, no back-to-back same channel.
REQ-036 Write priority: ch_ren[1]=ch_wen[1]=1, store 0x12345678 -> mem_wen=1, mem_ren=0, mem_store=0x12345678.
REQ-037 Stall stability: mem_wait high 5 cycles, ch_addr changed meanwhile -> mem_addr unchanged, ch_hit 2 cycles after mem_wait drops in cycle 6 window (DONE the cycle after).
REQ-038 Timeout: TIMEOUT=4, mem_wait high 10 cycles -> timeout_err rises after 4th wait cycle, stays high after completion until nRST.
REQ-039 Async reset mid-ACCESS: nRST low between edges -> mem_ren/mem_wen 0 immediately; after release no ch_hit until a new request.
